// File: rtl/branch_predict_if.sv
// Bundles the predictor's pipeline-facing signals. The pipeline side uses the
// master modport, the predictor uses slave. The dbg_* signals give read-only
// visibility of the PHT, the GHR and the decode counter.
//
// Protocol note: there is no valid/ready handshake on this bundle. Each stage
// qualifies its own request with a level signal: branchD marks a branch in
// decode, and branchE & ~stallE marks a training request in execute. A request
// is taken on every rising edge where it is high. Stall and flush are
// level-sensitive and are honoured on the same edge.
interface branch_predict_if #(
  parameter int PHT_BITS = 6,
  parameter int GHR_BITS = 6
);
  logic                stallD;
  logic                flushD;
  logic [31:0]         pcF;
  logic                branchD;
  logic                pred_takeD;
  logic [PHT_BITS-1:0] pht_indexD;
  logic                branchE;
  logic                stallE;
  logic                pred_takeE;
  logic [PHT_BITS-1:0] pht_indexE;
  logic                actual_takeE;
  logic                mispredictE;
  logic [PHT_BITS-1:0] dbg_index;
  logic [1:0]          dbg_ctr;
  logic [1:0]          dbg_ctrD;
  logic [GHR_BITS-1:0] dbg_ghr;

  modport master (
    output stallD, flushD, pcF, branchD, branchE, stallE, pred_takeE,
           pht_indexE, actual_takeE, dbg_index,
    input  pred_takeD, pht_indexD, mispredictE, dbg_ctr, dbg_ctrD, dbg_ghr
  );

  modport slave (
    input  stallD, flushD, pcF, branchD, branchE, stallE, pred_takeE,
           pht_indexE, actual_takeE, dbg_index,
    output pred_takeD, pht_indexD, mispredictE, dbg_ctr, dbg_ctrD, dbg_ghr
  );
endinterface

// File: rtl/branch_predict.sv
// Gshare direction predictor. Fetch looks up a table of 2-bit saturating
// counters at pcF XOR global history and registers the result into decode.
// Execute trains the table entry that made the prediction (its index travels
// down the pipeline) and shifts the resolved outcome into the history.
module branch_predict #(
  parameter int PHT_BITS = 6,
  parameter int GHR_BITS = 6
) (
  input logic             clk,
  input logic             resetn,
  branch_predict_if.slave bp
);
  localparam int ENTRIES = 1 << PHT_BITS;

  logic [1:0]          pht [ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [1:0]          ctr_d;
  logic [PHT_BITS-1:0] idx_d;

  logic [PHT_BITS-1:0] idx_f;
  logic                upd;
  logic [1:0]          ctr_e_old;
  logic [1:0]          ctr_e_new;
  logic [1:0]          ctr_f;

  // Only pcF[PHT_BITS+1:2] feeds the hash; the rest is intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^{bp.pcF[31:PHT_BITS+2], bp.pcF[1:0]};

  // History is zero-extended into the upper index bits when it is shorter.
  assign idx_f     = bp.pcF[PHT_BITS+1:2] ^ PHT_BITS'(ghr);
  assign upd       = bp.branchE & ~bp.stallE;
  assign ctr_e_old = pht[bp.pht_indexE];

  // Saturating counter step for the entry being trained, plus same-cycle
  // forwarding so decode never captures a counter that is about to change.
  always_comb begin
    ctr_e_new = ctr_e_old;
    if (bp.actual_takeE) begin
      if (ctr_e_old != 2'b11) ctr_e_new = ctr_e_old + 2'b01;
    end else begin
      if (ctr_e_old != 2'b00) ctr_e_new = ctr_e_old - 2'b01;
    end
    ctr_f = pht[idx_f];
    if (upd && (bp.pht_indexE == idx_f)) ctr_f = ctr_e_new;
  end

  // Pattern history table: every entry resets to weakly not-taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (upd) begin
      pht[bp.pht_indexE] <= ctr_e_new;
    end
  end

  // Non-speculative global history: shifts only when a branch trains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr <= '0;
    end else if (upd) begin
      ghr <= {ghr[GHR_BITS-2:0], bp.actual_takeE};
    end
  end

  // Decode-stage prediction registers; flush beats stall, stall holds without
  // late forwarding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctr_d <= 2'b01;
      idx_d <= '0;
    end else if (bp.flushD) begin
      ctr_d <= 2'b01;
      idx_d <= '0;
    end else if (!bp.stallD) begin
      ctr_d <= ctr_f;
      idx_d <= idx_f;
    end
  end

  assign bp.pred_takeD  = bp.branchD & ctr_d[1];
  assign bp.pht_indexD  = idx_d;
  assign bp.mispredictE = bp.branchE & (bp.pred_takeE ^ bp.actual_takeE);

  assign bp.dbg_ctr  = pht[bp.dbg_index];
  assign bp.dbg_ctrD = ctr_d;
  assign bp.dbg_ghr  = ghr;
endmodule

// File: tb/tb_branch_predict.sv
// Directed bench for the gshare predictor: reset defaults, saturation,
// history hashing, same-cycle forwarding, stall/flush handling, mispredict.
module tb_branch_predict;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  branch_predict_if #(.PHT_BITS(6), .GHR_BITS(6)) bp ();

  branch_predict #(.PHT_BITS(6), .GHR_BITS(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bp     (bp)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [5:0] idx, input logic taken);
    bp.branchE      = 1'b1;
    bp.stallE       = 1'b0;
    bp.pht_indexE   = idx;
    bp.actual_takeE = taken;
    step();
  endtask

  task automatic read_ctr(input logic [5:0] idx, output logic [1:0] ctr);
    bp.dbg_index = idx;
    #1;
    ctr = bp.dbg_ctr;
  endtask

  logic [1:0] c;

  initial begin
    checks = 0;
    errors = 0;
    resetn          = 1'b0;
    bp.stallD       = 1'b0;
    bp.flushD       = 1'b0;
    bp.pcF          = 32'h0040_0010;
    bp.branchD      = 1'b1;
    bp.branchE      = 1'b0;
    bp.stallE       = 1'b0;
    bp.pred_takeE   = 1'b0;
    bp.pht_indexE   = '0;
    bp.actual_takeE = 1'b0;
    bp.dbg_index    = '0;

    // Outputs while held in reset
    #1;
    check("rst_pred", 32'(bp.pred_takeD), 32'd0);
    check("rst_idx",  32'(bp.pht_indexD), 32'd0);
    step();
    step();
    resetn = 1'b1;

    // First lookup: 0x00400010 -> index 4, counter 01
    step();
    check("first_idx",  32'(bp.pht_indexD), 32'h04);
    check("first_pred", 32'(bp.pred_takeD), 32'd0);
    check("first_ghr",  32'(bp.dbg_ghr),    32'd0);

    // Mispredict is combinational and ignores stallE
    bp.branchE = 1'b1; bp.stallE = 1'b1; bp.pred_takeE = 1'b1; bp.actual_takeE = 1'b0;
    #1;
    check("mis_stalled", 32'(bp.mispredictE), 32'd1);
    bp.stallE = 1'b0;
    #1;
    check("mis_live", 32'(bp.mispredictE), 32'd1);
    bp.pred_takeE = 1'b0;
    #1;
    check("mis_correct", 32'(bp.mispredictE), 32'd0);
    bp.branchE = 1'b0; bp.pred_takeE = 1'b1;
    #1;
    check("mis_nobranch", 32'(bp.mispredictE), 32'd0);
    bp.pred_takeE = 1'b0;

    // Saturation up at index 5: 01 -> 10 -> 11 -> 11 -> 11
    train(6'd5, 1'b1); read_ctr(6'd5, c); check("sat_up1", 32'(c), 32'd2);
    train(6'd5, 1'b1); read_ctr(6'd5, c); check("sat_up2", 32'(c), 32'd3);
    train(6'd5, 1'b1); read_ctr(6'd5, c); check("sat_up3", 32'(c), 32'd3);
    train(6'd5, 1'b1); read_ctr(6'd5, c); check("sat_up4", 32'(c), 32'd3);
    check("sat_up_ghr", 32'(bp.dbg_ghr), 32'h0F);
    // ghr=001111: pc bits 0x0A ^ 0x0F = 5
    bp.branchE = 1'b0;
    bp.pcF     = 32'h0040_0028;
    step();
    check("sat_up_idx",  32'(bp.pht_indexD), 32'h05);
    check("sat_up_pred", 32'(bp.pred_takeD), 32'd1);

    // Saturation down: 11 -> 10 -> 01 -> 00 -> 00
    train(6'd5, 1'b0); read_ctr(6'd5, c); check("sat_dn1", 32'(c), 32'd2);
    train(6'd5, 1'b0); read_ctr(6'd5, c); check("sat_dn2", 32'(c), 32'd1);
    train(6'd5, 1'b0); read_ctr(6'd5, c); check("sat_dn3", 32'(c), 32'd0);
    train(6'd5, 1'b0); read_ctr(6'd5, c); check("sat_dn4", 32'(c), 32'd0);
    check("sat_dn_ghr", 32'(bp.dbg_ghr), 32'h30);
    // ghr=110000: pc bits 0x35 ^ 0x30 = 5
    bp.branchE = 1'b0;
    bp.pcF     = 32'h0040_00D4;
    step();
    check("sat_dn_idx",  32'(bp.pht_indexD), 32'h05);
    check("sat_dn_pred", 32'(bp.pred_takeD), 32'd0);

    // Mid-run reset with a training request pending
    bp.branchE = 1'b1; bp.stallE = 1'b0; bp.pht_indexE = 6'd5; bp.actual_takeE = 1'b1;
    bp.dbg_index = 6'd5;
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_ctr",  32'(bp.dbg_ctr),    32'd1);
    check("mid_rst_ghr",  32'(bp.dbg_ghr),    32'd0);
    check("mid_rst_idx",  32'(bp.pht_indexD), 32'd0);
    check("mid_rst_pred", 32'(bp.pred_takeD), 32'd0);
    check("mid_rst_ctrD", 32'(bp.dbg_ctrD),   32'd1);
    step();
    check("mid_rst_hold", 32'(bp.dbg_ctr), 32'd1);
    bp.branchE = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      read_ctr(6'(i), c);
      check($sformatf("rst_pht_%0d", i), 32'(c), 32'd1);
    end

    // History hashing: outcomes 1,0,1 -> ghr 000101; pc 0x00400000 -> index 5
    step();
    train(6'd10, 1'b1);
    train(6'd10, 1'b0);
    train(6'd10, 1'b1);
    check("hash_ghr", 32'(bp.dbg_ghr), 32'h05);
    read_ctr(6'd10, c); check("hash_ctr10", 32'(c), 32'd2);
    bp.branchE = 1'b0;
    bp.pcF     = 32'h0040_0000;
    step();
    check("hash_idx",  32'(bp.pht_indexD), 32'h05);
    check("hash_pred", 32'(bp.pred_takeD), 32'd0);

    // Forwarding: idxF = 6 ^ 5 = 3 while index 3 trains taken (01 -> 10)
    bp.pcF = 32'h0040_0018;
    train(6'd3, 1'b1);
    check("fwd_ctrD", 32'(bp.dbg_ctrD),   32'd2);
    check("fwd_pred", 32'(bp.pred_takeD), 32'd1);
    check("fwd_idx",  32'(bp.pht_indexD), 32'h03);
    read_ctr(6'd3, c); check("fwd_pht3", 32'(c), 32'd2);
    check("fwd_ghr", 32'(bp.dbg_ghr), 32'h0B);

    // Stalled execute trains once, when stallE drops
    bp.branchE = 1'b1; bp.stallE = 1'b1; bp.pht_indexE = 6'd3; bp.actual_takeE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      read_ctr(6'd3, c);
      check($sformatf("stallE_ctr_%0d", i), 32'(c), 32'd2);
      check($sformatf("stallE_ghr_%0d", i), 32'(bp.dbg_ghr), 32'h0B);
    end
    bp.stallE = 1'b0;
    step();
    bp.branchE = 1'b0;
    step();
    read_ctr(6'd3, c); check("stallE_once_ctr", 32'(c), 32'd3);
    check("stallE_once_ghr", 32'(bp.dbg_ghr), 32'h17);

    // Decode stall holds idxD/ctrD while the PHT still trains
    bp.pcF = 32'h0040_0000;
    step();
    check("stallD_pre_idx", 32'(bp.pht_indexD), 32'h17);
    bp.stallD = 1'b1;
    bp.pcF    = 32'h0040_0004;
    step();
    check("stallD_hold_idx", 32'(bp.pht_indexD), 32'h17);
    train(6'h16, 1'b1);
    check("stallD_train_idx",  32'(bp.pht_indexD), 32'h17);
    check("stallD_train_ctrD", 32'(bp.dbg_ctrD),   32'd1);
    read_ctr(6'h16, c); check("stallD_train_pht", 32'(c), 32'd2);
    check("stallD_train_ghr", 32'(bp.dbg_ghr), 32'h2F);

    // Load a strong counter into D: 0x2C ^ 0x2F = 3 (counter 11)
    bp.branchE = 1'b0;
    bp.stallD  = 1'b0;
    bp.pcF     = 32'h0040_00B0;
    step();
    check("preflush_idx",  32'(bp.pht_indexD), 32'h03);
    check("preflush_ctrD", 32'(bp.dbg_ctrD),   32'd3);

    // Flush beats stall; training in the same cycle still completes
    bp.flushD = 1'b1;
    bp.stallD = 1'b1;
    train(6'h20, 1'b1);
    check("flush_ctrD", 32'(bp.dbg_ctrD),   32'd1);
    check("flush_idx",  32'(bp.pht_indexD), 32'd0);
    check("flush_pred", 32'(bp.pred_takeD), 32'd0);
    read_ctr(6'h20, c); check("flush_train_pht", 32'(c), 32'd2);
    check("flush_train_ghr", 32'(bp.dbg_ghr), 32'h1F);
    bp.flushD  = 1'b0;
    bp.stallD  = 1'b0;
    bp.branchE = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
